intr_ctrl: RTL and testbench

INTR_CTRL -- requirements
Module: intr_ctrl

---
 rtl/intr_ctrl_if.sv | 37 +++
 rtl/intr_ctrl.sv | 98 +++++++++
 tb/tb_intr_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/intr_ctrl_if.sv
// Sequencer <-> interrupt controller bundle: requests, config writes, handshake.
// Latency: none (wires only).
// Backpressure: none; irq is held until the sequencer asserts ack.
interface intr_ctrl_if #(
    parameter int NINTR = 32,
    parameter int AW    = 12
);
    logic [NINTR-1:0] intr_req;
    logic             mask_we;
    logic [NINTR-1:0] mask_data;
    logic             tab_we;
    logic [4:0]       tab_addr;
    logic [AW-1:0]    tab_data;
    logic             enable;
    logic             boundary;
    logic             ack;
    logic             done;
    logic             irq;
    logic [AW-1:0]    vector;
    logic [4:0]       num;
    logic [NINTR-1:0] pending;
    logic             busy;

    // Sequencer side: drives requests, configuration and handshake.
    modport master (
        output intr_req, mask_we, mask_data, tab_we, tab_addr, tab_data,
               enable, boundary, ack, done,
        input  irq, vector, num, pending, busy
    );

    // Controller side.
    modport slave (
        input  intr_req, mask_we, mask_data, tab_we, tab_addr, tab_data,
               enable, boundary, ack, done,
        output irq, vector, num, pending, busy
    );
endinterface

// File: rtl/intr_ctrl.sv
// Priority interrupt controller: pending/mask registers, vector table, IDLE/REQ/SERVICE FSM.
// Latency: irq rises one cycle after an eligible source is seen at a boundary with enable.
// Backpressure: irq/num/vector held stable until ack; no new interrupt until done.
module intr_ctrl #(
    parameter int NINTR = 32,
    parameter int AW    = 12
) (
    input  logic        clk,
    input  logic        reset,
    intr_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [NINTR-1:0] pending_q, pending_d;
    logic [NINTR-1:0] mask_q;
    logic [4:0]       num_q, num_d;
    logic [AW-1:0]    vector_q, vector_d;
    logic [AW-1:0]    tab_q [32];

    logic [NINTR-1:0] elig;
    logic [NINTR-1:0] clr_vec;
    logic [4:0]       sel;

    assign elig = pending_q & ~mask_q;

    // Lowest eligible index wins: scan downwards so the last hit is the smallest index.
    always_comb begin
        sel = 5'd0;
        for (int i = NINTR - 1; i >= 0; i--) begin
            if (elig[i]) sel = 5'(i);
        end
    end

    // Clear the presented source on ack; a same-cycle request re-sets it (set wins).
    always_comb begin
        clr_vec = '0;
        if (state_q == REQ && bus.ack) clr_vec[num_q] = 1'b1;
        pending_d = (pending_q & ~clr_vec) | bus.intr_req;
    end

    // Next-state and latch values; the table read sees the pre-write word.
    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        vector_d = vector_q;
        case (state_q)
            IDLE: begin
                if (bus.boundary && bus.enable && (elig != '0)) begin
                    state_d  = REQ;
                    num_d    = sel;
                    vector_d = tab_q[sel];
                end
            end
            REQ: begin
                if (bus.ack) state_d = SERVICE;
            end
            SERVICE: begin
                if (bus.done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state, pending and mask registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            mask_q    <= '0;
            num_q     <= '0;
            vector_q  <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            num_q     <= num_d;
            vector_q  <= vector_d;
            if (bus.mask_we) mask_q <= bus.mask_data;
        end
    end

    // Vector table survives reset so firmware need not reload it.
    always_ff @(posedge clk) begin
        if (bus.tab_we) tab_q[bus.tab_addr] <= bus.tab_data;
    end

    assign bus.irq     = (state_q == REQ);
    assign bus.busy    = (state_q == SERVICE);
    assign bus.num     = num_q;
    assign bus.vector  = vector_q;
    assign bus.pending = pending_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed self-checking bench for intr_ctrl.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Expected values are hand-computed constants.
module tb_intr_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    intr_ctrl_if #(.NINTR(32), .AW(12)) bus ();

    intr_ctrl #(.NINTR(32), .AW(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset         = 1'b1;
        bus.intr_req  = '0;
        bus.mask_we   = 1'b0;
        bus.mask_data = '0;
        bus.tab_we    = 1'b0;
        bus.tab_addr  = '0;
        bus.tab_data  = '0;
        bus.enable    = 1'b0;
        bus.boundary  = 1'b0;
        bus.ack       = 1'b0;
        bus.done      = 1'b0;
        cyc(2);
        reset = 1'b0;

        // Reset state
        chk("rst_irq", 32'(bus.irq), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_num", 32'(bus.num), 32'h0);
        chk("rst_vector", 32'(bus.vector), 32'h0);
        chk("rst_pending", bus.pending, 32'h0);

        // Load vector table
        bus.tab_we = 1'b1;
        bus.tab_addr = 5'd3; bus.tab_data = 12'h44E; cyc(1);
        bus.tab_addr = 5'd5; bus.tab_data = 12'h155; cyc(1);
        bus.tab_addr = 5'd2; bus.tab_data = 12'h222; cyc(1);
        bus.tab_we = 1'b0;

        // Basic present / ack / done
        bus.intr_req = 32'h8; cyc(1); bus.intr_req = '0;
        chk("b_pend", bus.pending, 32'h8);
        chk("b_irq0", 32'(bus.irq), 32'h0);
        bus.boundary = 1'b1; bus.enable = 1'b1; cyc(1);
        bus.boundary = 1'b0; bus.enable = 1'b0;
        chk("b_irq", 32'(bus.irq), 32'h1);
        chk("b_num", 32'(bus.num), 32'd3);
        chk("b_vec", 32'(bus.vector), 32'h44E);
        cyc(1);
        chk("b_hold_irq", 32'(bus.irq), 32'h1);
        chk("b_hold_vec", 32'(bus.vector), 32'h44E);
        bus.ack = 1'b1; cyc(1); bus.ack = 1'b0;
        chk("b_ack_pend", bus.pending, 32'h0);
        chk("b_ack_busy", 32'(bus.busy), 32'h1);
        chk("b_ack_irq", 32'(bus.irq), 32'h0);
        bus.done = 1'b1; cyc(1); bus.done = 1'b0;
        chk("b_done_busy", 32'(bus.busy), 32'h0);

        // Priority: 2 before 5, earliest re-entry
        bus.intr_req = 32'h24; cyc(1); bus.intr_req = '0;
        chk("p_pend", bus.pending, 32'h24);
        bus.boundary = 1'b1; bus.enable = 1'b1; cyc(1);
        chk("p_num2", 32'(bus.num), 32'd2);
        chk("p_vec2", 32'(bus.vector), 32'h222);
        bus.ack = 1'b1; cyc(1); bus.ack = 1'b0;
        chk("p_svc_irq", 32'(bus.irq), 32'h0);
        chk("p_svc_busy", 32'(bus.busy), 32'h1);
        chk("p_svc_pend", bus.pending, 32'h20);
        cyc(1);
        chk("p_svc_noirq", 32'(bus.irq), 32'h0);
        bus.done = 1'b1; cyc(1); bus.done = 1'b0;
        chk("p_idle_busy", 32'(bus.busy), 32'h0);
        chk("p_idle_irq", 32'(bus.irq), 32'h0);
        cyc(1);
        chk("p_irq5", 32'(bus.irq), 32'h1);
        chk("p_num5", 32'(bus.num), 32'd5);
        chk("p_vec5", 32'(bus.vector), 32'h155);
        bus.boundary = 1'b0;
        bus.ack = 1'b1; cyc(1); bus.ack = 1'b0;
        bus.done = 1'b1; cyc(1); bus.done = 1'b0;
        chk("p_end_pend", bus.pending, 32'h0);

        // Mask, then unmask; same-cycle table write sees old word
        bus.mask_we = 1'b1; bus.mask_data = 32'h4; cyc(1); bus.mask_we = 1'b0;
        bus.intr_req = 32'h4; cyc(1); bus.intr_req = '0;
        bus.boundary = 1'b1; bus.enable = 1'b1; cyc(2);
        chk("m_pend", bus.pending, 32'h4);
        chk("m_irq0", 32'(bus.irq), 32'h0);
        bus.mask_we = 1'b1; bus.mask_data = '0; cyc(1); bus.mask_we = 1'b0;
        chk("m_wr_irq0", 32'(bus.irq), 32'h0);
        bus.tab_we = 1'b1; bus.tab_addr = 5'd2; bus.tab_data = 12'h333; cyc(1);
        bus.tab_we = 1'b0;
        chk("m_irq", 32'(bus.irq), 32'h1);
        chk("m_num", 32'(bus.num), 32'd2);
        chk("m_oldvec", 32'(bus.vector), 32'h222);

        // ack and request on same source: set wins, re-presented
        bus.ack = 1'b1; bus.intr_req = 32'h4; cyc(1);
        bus.ack = 1'b0; bus.intr_req = '0;
        chk("s_pend", bus.pending, 32'h4);
        chk("s_busy", 32'(bus.busy), 32'h1);
        bus.done = 1'b1; cyc(1); bus.done = 1'b0;
        chk("s_idle", 32'(bus.busy), 32'h0);
        cyc(1);
        chk("s_irq", 32'(bus.irq), 32'h1);
        chk("s_num", 32'(bus.num), 32'd2);
        chk("s_newvec", 32'(bus.vector), 32'h333);

        // Reset while in REQ
        reset = 1'b1; bus.boundary = 1'b0; bus.enable = 1'b0; cyc(1);
        reset = 1'b0;
        chk("r_irq", 32'(bus.irq), 32'h0);
        chk("r_busy", 32'(bus.busy), 32'h0);
        chk("r_pend", bus.pending, 32'h0);
        chk("r_num", 32'(bus.num), 32'h0);
        chk("r_vec", 32'(bus.vector), 32'h0);

        // Gating by enable/boundary; stray ack/done in IDLE ignored
        bus.intr_req = 32'h8; cyc(1); bus.intr_req = '0;
        bus.enable = 1'b0; bus.boundary = 1'b1; bus.ack = 1'b1; bus.done = 1'b1; cyc(1);
        chk("g_en_irq", 32'(bus.irq), 32'h0);
        chk("g_en_busy", 32'(bus.busy), 32'h0);
        chk("g_en_pend", bus.pending, 32'h8);
        bus.enable = 1'b1; bus.boundary = 1'b0; cyc(1);
        chk("g_bd_irq", 32'(bus.irq), 32'h0);
        chk("g_bd_pend", bus.pending, 32'h8);
        bus.ack = 1'b0; bus.done = 1'b0; bus.boundary = 1'b1; cyc(1);
        chk("g_irq", 32'(bus.irq), 32'h1);
        chk("g_num", 32'(bus.num), 32'd3);
        chk("g_tabkept", 32'(bus.vector), 32'h44E);
        bus.boundary = 1'b0;
        bus.done = 1'b1; cyc(1); bus.done = 1'b0;
        chk("g_done_in_req", 32'(bus.irq), 32'h1);
        chk("g_done_busy", 32'(bus.busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
